// File: rtl/star_bbox_finder.sv
// Raster-scan star locator: thresholds a frame of pixels, tracks the bounding box of bright
// pixels, then launches the box drawer and waits for its done handshake.
module star_bbox_finder #(
   parameter int unsigned xSz    = 3,
   parameter int unsigned ySz    = 3,
   parameter int unsigned pixSz  = 3,
   parameter int unsigned THRESH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pixValid,
   input  logic [pixSz-1:0] pixData,
   output logic             pixReady,
   input  logic             doneDraw,
   output logic             goDraw,
   output logic [xSz-1:0]   xLeft,
   output logic [xSz-1:0]   xRight,
   output logic [ySz-1:0]   yTop,
   output logic [ySz-1:0]   yBottom,
   output logic             busy
);

   typedef enum logic [1:0] {
      StScan,
      StLaunch,
      StWaitStart,
      StWaitDone
   } state_t;

   state_t         state;
   logic [xSz-1:0] xPos;
   logic [ySz-1:0] yPos;
   logic [xSz-1:0] minX;
   logic [xSz-1:0] maxX;
   logic [ySz-1:0] minY;
   logic [ySz-1:0] maxY;
   logic           found;

   logic           accept;
   logic           bright;
   logic           lastX;
   logic           lastPix;
   logic [xSz-1:0] nMinX;
   logic [xSz-1:0] nMaxX;
   logic [ySz-1:0] nMinY;
   logic [ySz-1:0] nMaxY;

   assign pixReady = (state == StScan);
   assign busy     = (state != StScan);
   assign accept   = pixValid && (state == StScan);
   // Widen before comparing so a threshold beyond the pixel range simply never matches.
   assign bright   = 32'(pixData) >= THRESH;
   assign lastX    = (xPos == {xSz{1'b1}});
   assign lastPix  = lastX && (yPos == {ySz{1'b1}});

   // Tracker values including the current pixel, valid when that pixel is bright.
   always_comb begin
      nMinX = xPos;
      nMaxX = xPos;
      nMinY = yPos;
      nMaxY = yPos;
      if (found) begin
         if (minX < xPos) nMinX = minX;
         if (maxX > xPos) nMaxX = maxX;
         if (minY < yPos) nMinY = minY;
         if (maxY > yPos) nMaxY = maxY;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= StScan;
         xPos    <= '0;
         yPos    <= '0;
         minX    <= '0;
         maxX    <= '0;
         minY    <= '0;
         maxY    <= '0;
         found   <= 1'b0;
         goDraw  <= 1'b0;
         xLeft   <= '0;
         xRight  <= '0;
         yTop    <= '0;
         yBottom <= '0;
      end else begin
         goDraw <= 1'b0;
         case (state)
            StScan: begin
               if (accept) begin
                  xPos <= xPos + xSz'(1);
                  if (lastX) yPos <= yPos + ySz'(1);
                  if (bright) begin
                     minX  <= nMinX;
                     maxX  <= nMaxX;
                     minY  <= nMinY;
                     maxY  <= nMaxY;
                     found <= 1'b1;
                  end
                  if (lastPix) begin
                     if (found || bright) begin
                        xLeft   <= bright ? nMinX : minX;
                        xRight  <= bright ? nMaxX : maxX;
                        yTop    <= bright ? nMinY : minY;
                        yBottom <= bright ? nMaxY : maxY;
                        goDraw  <= 1'b1;
                        state   <= StLaunch;
                     end else begin
                        xPos  <= '0;
                        yPos  <= '0;
                        minX  <= '0;
                        maxX  <= '0;
                        minY  <= '0;
                        maxY  <= '0;
                        found <= 1'b0;
                     end
                  end
               end
            end
            StLaunch: begin
               state <= StWaitStart;
            end
            StWaitStart: begin
               if (!doneDraw) state <= StWaitDone;
            end
            StWaitDone: begin
               if (doneDraw) begin
                  xPos  <= '0;
                  yPos  <= '0;
                  minX  <= '0;
                  maxX  <= '0;
                  minY  <= '0;
                  maxY  <= '0;
                  found <= 1'b0;
                  state <= StScan;
               end
            end
            default: state <= StScan;
         endcase
      end
   end

endmodule

// File: tb/tb_star_bbox_finder.sv
// Scoreboard bench for star_bbox_finder: a bounding-box model pushes the expected box per frame,
// and each observed goDraw pops and compares it.
module tb_star_bbox_finder;

   typedef struct packed {
      logic [2:0] xl;
      logic [2:0] xr;
      logic [2:0] yt;
      logic [2:0] yb;
   } box_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       pixValid;
   logic [2:0] pixData;
   logic       pixReady;
   logic       doneDraw;
   logic       goDraw;
   logic [2:0] xLeft;
   logic [2:0] xRight;
   logic [2:0] yTop;
   logic [2:0] yBottom;
   logic       busy;

   int         checks = 0;
   int         errors = 0;
   box_t       exp_q[$];
   box_t       cur_box;
   logic [2:0] frm[64];

   always #5 clk = ~clk;

   star_bbox_finder #(
      .xSz(3), .ySz(3), .pixSz(3), .THRESH(4)
   ) dut (
      .clk(clk), .reset(reset), .pixValid(pixValid), .pixData(pixData), .pixReady(pixReady),
      .doneDraw(doneDraw), .goDraw(goDraw), .xLeft(xLeft), .xRight(xRight), .yTop(yTop),
      .yBottom(yBottom), .busy(busy)
   );

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic box_t dut_box();
      box_t b;
      b.xl = xLeft;
      b.xr = xRight;
      b.yt = yTop;
      b.yb = yBottom;
      return b;
   endfunction

   task automatic clear_frame();
      for (int i = 0; i < 64; i++) frm[i] = 3'd0;
   endtask

   task automatic set_pix(input int x, input int y, input logic [2:0] v);
      frm[y*8 + x] = v;
   endtask

   // Reference model: bounding box of all pixels at or above the threshold of 4.
   function automatic bit model_box(output box_t b);
      bit any = 1'b0;
      int mnx = 7, mxx = 0, mny = 7, mxy = 0;
      for (int i = 0; i < 64; i++) begin
         if (frm[i] >= 3'd4) begin
            any = 1'b1;
            if (i % 8 < mnx) mnx = i % 8;
            if (i % 8 > mxx) mxx = i % 8;
            if (i / 8 < mny) mny = i / 8;
            if (i / 8 > mxy) mxy = i / 8;
         end
      end
      b.xl = 3'(mnx);
      b.xr = 3'(mxx);
      b.yt = 3'(mny);
      b.yb = 3'(mxy);
      return any;
   endfunction

   // Drives the first n pixels of frm; a full frame with bright pixels pushes its box.
   task automatic drive_frame(input int n, input bit gaps, input string name);
      int   idx = 0;
      int   cyc = 0;
      bit   bad = 1'b0;
      box_t b;
      if (n == 64 && model_box(b)) exp_q.push_back(b);
      while (idx < n && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         if (pixReady !== 1'b1 || goDraw !== 1'b0 || busy !== 1'b0) bad = 1'b1;
         pixValid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         pixData  = frm[idx];
         @(posedge clk);
         if (pixValid) idx++;
      end
      #1 pixValid = 1'b0;
      checks++;
      if (bad || idx != n) begin
         errors++;
         $display("FAIL %s scan: bad_scan_outputs=%0b accepted=%0d, required 0 and %0d",
                  name, bad, idx, n);
      end
   endtask

   // Called right after the final accept edge: goDraw must be high in this very cycle only.
   task automatic expect_launch(input string name);
      box_t exp_b;
      @(negedge clk);
      checks++;
      if (goDraw !== 1'b1) begin
         errors++;
         $display("FAIL %s latency: goDraw=%b, required 1", name, goDraw);
      end
      checks++;
      if (busy !== 1'b1 || pixReady !== 1'b0) begin
         errors++;
         $display("FAIL %s launch state: busy=%b pixReady=%b, required 1 0", name, busy, pixReady);
      end
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s box: launch seen with empty scoreboard, required no launch", name);
      end else begin
         exp_b   = exp_q.pop_front();
         cur_box = exp_b;
         if (dut_box() !== exp_b) begin
            errors++;
            $display("FAIL %s box: got %0d,%0d,%0d,%0d required %0d,%0d,%0d,%0d", name,
                     xLeft, xRight, yTop, yBottom, exp_b.xl, exp_b.xr, exp_b.yt, exp_b.yb);
         end
      end
      @(negedge clk);
      checks++;
      if (goDraw !== 1'b0) begin
         errors++;
         $display("FAIL %s pulse width: goDraw=%b one cycle later, required 0", name, goDraw);
      end
   endtask

   task automatic drawer(input int hold, input int low, input string name);
      bit bad = 1'b0;
      repeat (hold) begin
         @(negedge clk);
         if (pixReady !== 1'b0 || busy !== 1'b1 || goDraw !== 1'b0 || dut_box() !== cur_box)
            bad = 1'b1;
      end
      doneDraw = 1'b0;
      repeat (low) begin
         @(negedge clk);
         if (pixReady !== 1'b0 || busy !== 1'b1 || goDraw !== 1'b0 || dut_box() !== cur_box)
            bad = 1'b1;
      end
      doneDraw = 1'b1;
      @(negedge clk);
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL %s stall: outputs moved while drawing (bad=%0b), required 0", name, bad);
      end
      checks++;
      if (pixReady !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s release: pixReady=%b busy=%b, required 1 0", name, pixReady, busy);
      end
   endtask

   task automatic check_idle(input string name);
      checks++;
      if (pixReady !== 1'b1 || goDraw !== 1'b0 || busy !== 1'b0 || dut_box() !== box_t'(0)) begin
         errors++;
         $display("FAIL %s: pixReady=%b goDraw=%b busy=%b box=%0d,%0d,%0d,%0d, required 1 0 0 0,0,0,0",
                  name, pixReady, goDraw, busy, xLeft, xRight, yTop, yBottom);
      end
   endtask

   task automatic test_reset();
      reset    = 1'b1;
      pixValid = 1'b0;
      pixData  = 3'd0;
      doneDraw = 1'b1;
      repeat (2) @(negedge clk);
      check_idle("reset values");
      reset = 1'b0;
   endtask

   task automatic test_single();
      clear_frame();
      set_pix(3, 5, 3'd5);
      drive_frame(64, 1'b0, "single");
      expect_launch("single");
      drawer(1, 4, "single");
   endtask

   task automatic load_two_pixel();
      clear_frame();
      set_pix(1, 2, 3'd4);
      set_pix(6, 0, 3'd4);
      set_pix(7, 7, 3'd3);
   endtask

   task automatic test_two_pixel();
      load_two_pixel();
      drive_frame(64, 1'b0, "two_pixel");
      expect_launch("two_pixel");
      drawer(1, 2, "two_pixel");
   endtask

   task automatic test_dark();
      bit bad = 1'b0;
      clear_frame();
      drive_frame(64, 1'b0, "dark");
      repeat (6) begin
         @(negedge clk);
         if (goDraw !== 1'b0 || busy !== 1'b0 || pixReady !== 1'b1) bad = 1'b1;
      end
      checks++;
      if (bad || exp_q.size() != 0) begin
         errors++;
         $display("FAIL dark no-launch: bad=%0b queued=%0d, required 0 0", bad, exp_q.size());
      end
      set_pix(7, 7, 3'd7);
      drive_frame(64, 1'b0, "last_pixel");
      expect_launch("last_pixel");
      drawer(1, 3, "last_pixel");
   endtask

   task automatic test_stall();
      load_two_pixel();
      drive_frame(64, 1'b0, "stall");
      expect_launch("stall");
      drawer(2, 20, "stall");
   endtask

   task automatic test_gaps();
      load_two_pixel();
      drive_frame(64, 1'b1, "gaps");
      expect_launch("gaps");
      drawer(1, 5, "gaps");
   endtask

   task automatic test_reset_mid_frame();
      clear_frame();
      set_pix(2, 1, 3'd6);
      drive_frame(20, 1'b0, "partial");
      #2 reset = 1'b1;
      #1 check_idle("reset mid-frame");
      @(negedge clk);
      reset = 1'b0;
      clear_frame();
      set_pix(5, 6, 3'd7);
      drive_frame(64, 1'b0, "after_reset");
      expect_launch("after_reset");
      drawer(0, 3, "after_reset");
   endtask

   task automatic test_reset_launch();
      box_t dropped;
      clear_frame();
      set_pix(0, 0, 3'd4);
      drive_frame(64, 1'b0, "reset_launch");
      checks++;
      if (goDraw !== 1'b1) begin
         errors++;
         $display("FAIL reset_launch pre: goDraw=%b, required 1", goDraw);
      end
      if (exp_q.size() != 0) dropped = exp_q.pop_front();
      #2 reset = 1'b1;
      #1 check_idle("reset during launch");
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_two_pixel();
      test_dark();
      test_stall();
      test_gaps();
      test_reset_mid_frame();
      test_reset_launch();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard drain: %0d boxes never launched, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
